// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive control unit.
// The PARITY state exists only when RCU_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int unsigned CPB_MIN   = 4;
  localparam int unsigned CPB_MAX   = 1024;
  localparam int unsigned DBITS_MIN = 5;
  localparam int unsigned DBITS_MAX = 9;
  localparam int unsigned SBITS_MIN = 1;
  localparam int unsigned SBITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RCU_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_CHK,
    ST_LOAD
  } rcu_state_t;

  // START only waits half a bit so that every later tick lands mid-bit.
  function automatic int unsigned rcu_terminal(input rcu_state_t s, input int unsigned cpb);
    return (s == ST_START) ? (cpb / 2 - 1) : (cpb - 1);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: ticks at the half or full terminal count, restarts on
// clear or after each tick.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half_sel,
  output logic tick
);
  import uart_rx_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TERM = CW'(rcu_terminal(ST_START, CLKS_PER_BIT));
  localparam logic [CW-1:0] FULL_TERM = CW'(rcu_terminal(ST_DATA, CLKS_PER_BIT));

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == (half_sel ? HALF_TERM : FULL_TERM));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rcu_gen.sv
// UART receiver control unit: frame sequencing, shift/load strobes, error flags.
// Optional parity checking is compiled in with RCU_PARITY_EN.
//   state  | meaning
//   IDLE   | waiting for start_bit_detected
//   START  | half-bit wait, confirm start bit is still low
//   DATA   | one shift_strobe per data bit
//   PARITY | sample and check parity bit (RCU_PARITY_EN only)
//   STOP   | sample stop bit(s), note framing failure
//   CHK    | publish error flags, decide whether to load
//   LOAD   | one-cycle load_buffer pulse
module uart_rcu_gen #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic parity_error,
  output logic overrun_error,
  output logic busy
);
  import uart_rx_pkg::*;

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < CPB_MIN || CLKS_PER_BIT > CPB_MAX || CLKS_PER_BIT[0] ||
      DATA_BITS < DBITS_MIN || DATA_BITS > DBITS_MAX ||
      STOP_BITS < SBITS_MIN || STOP_BITS > SBITS_MAX) begin : g_bad_cfg
    $error("uart_rcu_gen: unsupported parameter set");
  end

  rcu_state_t    state_q, state_d;
  logic          tick, half_sel, timer_clear, frame_start;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          frm_pend_q, frm_pend_d;
  logic          framing_error_q, framing_error_d;
  logic          data_ready_q, data_ready_d;
  logic          overrun_q, overrun_d;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .half_sel (half_sel),
    .tick     (tick)
  );

  assign frame_start = (state_q == ST_IDLE) && start_bit_detected;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_bit_detected) state_d = ST_START;
      ST_START: if (tick) state_d = serial_in ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick && (bit_cnt_q == BW'(DATA_BITS - 1))) begin
`ifdef RCU_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef RCU_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick && (bit_cnt_q == BW'(STOP_BITS - 1))) state_d = ST_CHK;
      ST_CHK:   state_d = frm_pend_q ? ST_IDLE : ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    load_buffer  = (state_q == ST_LOAD);
    shift_strobe = (state_q == ST_DATA) && tick;
    half_sel     = (state_q == ST_START);
    timer_clear  = (state_d != state_q) || (state_q == ST_IDLE);
  end

  // bit_cnt counts data ticks in DATA and stop ticks in STOP.
  always_comb begin
    bit_cnt_d       = bit_cnt_q;
    frm_pend_d      = frm_pend_q;
    framing_error_d = framing_error_q;
    data_ready_d    = data_ready_q;
    overrun_d       = overrun_q;
    if (timer_clear) bit_cnt_d = '0;
    else if (tick && (state_q == ST_DATA || state_q == ST_STOP)) bit_cnt_d = bit_cnt_q + BW'(1);
    if (frame_start) frm_pend_d = 1'b0;
    else if (state_q == ST_STOP && tick && !serial_in) frm_pend_d = 1'b1;
    if (state_q == ST_CHK) framing_error_d = frm_pend_q;
    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (state_q == ST_LOAD) begin
      data_ready_d = 1'b1;
      if (data_ready_q && !data_read) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q       <= '0;
      frm_pend_q      <= 1'b0;
      framing_error_q <= 1'b0;
      data_ready_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      bit_cnt_q       <= bit_cnt_d;
      frm_pend_q      <= frm_pend_d;
      framing_error_q <= framing_error_d;
      data_ready_q    <= data_ready_d;
      overrun_q       <= overrun_d;
    end
  end

  assign framing_error = framing_error_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;

`ifdef RCU_PARITY_EN
  logic par_acc_q, par_acc_d, par_pend_q, par_pend_d, parity_error_q, parity_error_d;

  always_comb begin
    par_acc_d      = par_acc_q;
    par_pend_d     = par_pend_q;
    parity_error_d = parity_error_q;
    if (frame_start) begin
      par_acc_d  = 1'b0;
      par_pend_d = 1'b0;
    end else if (tick && state_q == ST_DATA) begin
      par_acc_d = par_acc_q ^ serial_in;
    end else if (tick && state_q == ST_PARITY) begin
      par_acc_d  = par_acc_q ^ serial_in;
      par_pend_d = ((par_acc_q ^ serial_in) != PARITY_ODD);
    end
    if (state_q == ST_CHK) parity_error_d = par_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc_q      <= 1'b0;
      par_pend_q     <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      par_acc_q      <= par_acc_d;
      par_pend_q     <= par_pend_d;
      parity_error_q <= parity_error_d;
    end
  end

  assign parity_error = parity_error_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign parity_error      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcu_gen.sv
// Directed bench for uart_rcu_gen at 16 clocks/bit, 8 data bits, 1 stop bit.
`timescale 1ns/1ps
module tb_uart_rcu_gen;
`ifdef RCU_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LOAD_CYC = 154 + 16 * PB;
  localparam int FRAME_CYC = 160 + 16 * PB;

  logic clk = 1'b0;
  logic rst, sbd, serial_in, data_read;
  logic shift_strobe, load_buffer, data_ready, framing_error, parity_error, overrun_error, busy;

  int checks = 0;
  int errors = 0;

  int n_strobe, first_strobe, last_strobe, load_cyc, start_cyc, idle_cyc, dr_rise, fe_rise;
  logic [7:0] shreg;
  logic [6:0] probe_vec;

  always #5 clk = ~clk;

  uart_rcu_gen #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start_bit_detected(sbd), .serial_in(serial_in),
    .data_read(data_read), .shift_strobe(shift_strobe), .load_buffer(load_buffer),
    .data_ready(data_ready), .framing_error(framing_error), .parity_error(parity_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_pbit(input logic [7:0] d);
    return ~^d;
  endfunction

  // Cycle 0 carries start_bit_detected; line bit n spans cycles 16n..16n+15.
  task automatic run_frame(input logic [7:0] data, input logic pbit, input logic stop_val,
                           input logic glitch, input logic read_at_load, input int rst_at,
                           input int ncyc, input int probe);
    logic [15:0] bits;
    logic prev_dr, prev_fe, prev_busy;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (PB == 1) bits[9] = pbit;
    bits[9+PB] = stop_val;
    n_strobe = 0; first_strobe = -1; last_strobe = -1; load_cyc = -1;
    start_cyc = -1; idle_cyc = -1; dr_rise = -1; fe_rise = -1; shreg = '0; probe_vec = '1;
    prev_dr = data_ready; prev_fe = framing_error; prev_busy = busy;
    for (int c = 0; c < ncyc; c++) begin
      sbd = (c == 0);
      rst = (c == rst_at);
      serial_in = bits[c/16];
      if (glitch && c >= 6) serial_in = 1'b1;
      data_read = 1'b0;
      #2;
      if (shift_strobe) begin
        n_strobe++;
        if (first_strobe < 0) first_strobe = c;
        last_strobe = c;
        shreg = {serial_in, shreg[7:1]};
      end
      if (load_buffer) begin
        if (load_cyc < 0) load_cyc = c;
        data_read = read_at_load;
      end
      if (busy && start_cyc < 0) start_cyc = c;
      if (!busy && prev_busy && idle_cyc < 0) idle_cyc = c;
      if (data_ready && !prev_dr && dr_rise < 0) dr_rise = c;
      if (framing_error && !prev_fe && fe_rise < 0) fe_rise = c;
      if (c == probe) probe_vec = {busy, shift_strobe, load_buffer, data_ready,
                                   framing_error, parity_error, overrun_error};
      prev_dr = data_ready; prev_fe = framing_error; prev_busy = busy;
      @(posedge clk); #1;
    end
    sbd = 1'b0; rst = 1'b0; data_read = 1'b0; serial_in = 1'b1;
  endtask

  task automatic pulse_read(input string tag);
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    check_eq({tag, "_dr"}, data_ready, 1'b0);
    check_eq({tag, "_oe"}, overrun_error, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sbd = 1'b0; serial_in = 1'b1; data_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {busy, shift_strobe, load_buffer, data_ready,
                            framing_error, parity_error, overrun_error}, 7'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_frame(8'hA5, odd_pbit(8'hA5), 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("nom_start", start_cyc, 1);
    check_eq("nom_first_strobe", first_strobe, 24);
    check_eq("nom_last_strobe", last_strobe, 136);
    check_eq("nom_n_strobe", n_strobe, 8);
    check_eq("nom_data", shreg, 8'hA5);
    check_eq("nom_load", load_cyc, LOAD_CYC);
    check_eq("nom_dr_rise", dr_rise, LOAD_CYC + 1);
    check_eq("nom_errs", {framing_error, parity_error, overrun_error}, 3'b000);

    run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, -1, 20, -1);
    check_eq("glitch_idle", idle_cyc, 9);
    check_eq("glitch_n_strobe", n_strobe, 0);
    check_eq("glitch_flags", {data_ready, framing_error, parity_error, overrun_error}, 4'b1000);
    pulse_read("read1");

    run_frame(8'h3C, odd_pbit(8'h3C), 1'b0, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("frm_load", load_cyc, -1);
    check_eq("frm_fe_rise", fe_rise, LOAD_CYC);
    check_eq("frm_dr", data_ready, 1'b0);
    check_eq("frm_n_strobe", n_strobe, 8);

    run_frame(8'h5A, odd_pbit(8'h5A), 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("ovr1_flags", {data_ready, framing_error, overrun_error}, 3'b100);
    check_eq("ovr1_data", shreg, 8'h5A);
    run_frame(8'h0F, odd_pbit(8'h0F), 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, LOAD_CYC + 1);
    check_eq("ovr2_probe_oe", probe_vec[0], 1'b1);
    check_eq("ovr2_flags", {data_ready, overrun_error}, 2'b11);
    check_eq("ovr2_data", shreg, 8'h0F);
    pulse_read("read2");

    run_frame(8'h11, odd_pbit(8'h11), 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("coin1_dr", data_ready, 1'b1);
    run_frame(8'h22, odd_pbit(8'h22), 1'b1, 1'b0, 1'b1, -1, FRAME_CYC, -1);
    check_eq("coin2_load", load_cyc, LOAD_CYC);
    check_eq("coin2_flags", {data_ready, overrun_error}, 2'b10);

    run_frame(8'h77, odd_pbit(8'h77), 1'b1, 1'b0, 1'b0, 56, FRAME_CYC, 57);
    check_eq("rst_n_strobe", n_strobe, 3);
    check_eq("rst_outs", probe_vec, 7'd0);
    check_eq("rst_load", load_cyc, -1);

    run_frame(8'h96, odd_pbit(8'h96), 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("post_rst_load", load_cyc, LOAD_CYC);
    check_eq("post_rst_data", shreg, 8'h96);
    check_eq("post_rst_dr_rise", dr_rise, LOAD_CYC + 1);
    check_eq("post_rst_errs", {framing_error, parity_error, overrun_error}, 3'b000);

`ifdef RCU_PARITY_EN
    pulse_read("read3");
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("par_bad_pe", parity_error, 1'b1);
    check_eq("par_bad_load", load_cyc, LOAD_CYC);
    pulse_read("read4");
    run_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, -1, FRAME_CYC, -1);
    check_eq("par_good_pe", parity_error, 1'b0);
    check_eq("par_good_load", load_cyc, LOAD_CYC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
